rom_image_loader: RTL and testbench
===================================

Name: rom_image_loader

Overview:
Write-side companion to the synchronous single-port ROM/RAM: accepts a byte stream from the host/bridge and packs it into dw-bit words. It writes those words sequentially from address 0 into a single-port memory through a one-cycle write strobe. The block sits between the bridge data path and the boot/character ROM arrays, so ROM images are loaded at run time instead of through an init file.

Parameters:
aw, 10, memory address width (memory holds 2^aw words)
dw, 32, memory data width; must be a multiple of 8 (elaboration error otherwise)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active high
start  input  1  one-cycle pulse: begin a new load at address 0
in_valid  input  1  byte on in_data is valid
in_data  input  8  stream byte
in_last  input  1  qualifies in_valid; this byte ends the image
in_ready  output  1  block accepts a byte this cycle (transfer = in_valid & in_ready)
wr_en  output  1  memory write strobe, one cycle per word
wr_addr  output  aw  memory write address
wr_data  output  dw  memory write data
busy  output  1  load in progress
done  output  1  load finished; sticky until the next start or rst
overflow  output  1  bytes arrived after the memory was full; sticky until the next start or rst
words_written  output  aw+1  count of words written in the current load

Behaviour:
- Reset (rst high at a clk edge) clears all outputs and state: in_ready, wr_en, busy, done and overflow are 0; wr_addr, wr_data and words_written are 0. The state machine goes to IDLE.
- Constant NB = dw/8 bytes per word. Bytes are packed little-endian: the first byte of a word goes to [7:0], the NB-th byte to [dw-1:dw-8]. A byte index counter runs 0..NB-1.
- IDLE:
  - in_ready=0 and busy=0.
  - start moves the block to COLLECT, clears the address, words_written, byte index, done and overflow.
  - A byte presented in the same cycle as start is not accepted.
- COLLECT:
  - in_ready=1 and busy=1.
  - On each transfer the byte is stored at the current byte index and the index increments.
  - When the NB-th byte is transferred, or in_last is transferred, go to WRITE.
  - On in_last with a partial word, the unfilled upper bytes are 0.
- WRITE:
  - Lasts exactly one cycle, with wr_en=1 and in_ready=0.
  - wr_addr and wr_data hold the assembled word.
  - Latency: the word's final byte is accepted at cycle N; wr_en is high at cycle N+1.
  - On the next edge: words_written increments, wr_addr increments, the byte index and assembly register clear.
  - Next state is DONE if the word ended with in_last or the word written was at address 2^aw-1; otherwise COLLECT.
- wr_addr wrap: wr_addr never wraps in use. Reaching a full memory forces DONE, and words_written reads 2^aw.
- DONE:
  - done=1, busy=0.
  - in_ready=1 so that excess bytes are drained and discarded.
  - Any transfer in DONE that arrives before in_last sets overflow; an in_last transfer ends the drain and returns the block to IDLE with done kept at 1.
  - If the image ended on in_last, DONE returns to IDLE after one cycle.
- start received while busy (COLLECT or WRITE) aborts the load and restarts at address 0.
  - A partially assembled word is discarded.
  - If start coincides with WRITE, that write still happens (wr_en=1 that cycle), and the counters are then reset to 0.
- start in DONE behaves as in IDLE.
- in_valid with in_ready=0 is ignored; the source holds the byte.
- wr_en is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, COLLECT, WRITE, DONE),
  - the NB derivation function,
  - the byte-order constant, so a future reader/CRC block packs bytes identically.
- One natural sub-module, byte_packer: byte index counter, little-endian assembly register, zero padding, with clear and full outputs.
- The FSM and address/count logic stay in rom_image_loader.

Test Plan:
- Defaults. Reset, start, then 8 bytes 01..08 with in_last on 08 → wr_en at addr 0 with data 0x04030201, then addr 1 with 0x08070605; done=1 and words_written=2.
- Partial word. Bytes AA,BB,CC with in_last on CC → single write at addr 0 with data 0x00CCBBAA; done=1.
- Full memory, aw=2. 20 bytes without in_last → 4 writes at addr 0..3, then done=1 and words_written=4. The 4 bytes after the 16th are accepted and set overflow=1; no extra wr_en.
- Abort. start, bytes 11,22,33,44,55,66, start again, then 4 bytes A1..A4 with in_last → writes 0x44332211 at addr 0, then 0xA4A3A2A1 at addr 0; words_written=1.
- Back-pressure and latency. in_valid held high continuously → in_ready drops for exactly one cycle after every 4th byte; wr_en is high exactly one cycle after that byte is accepted.
- Reset mid-load. rst after 2 bytes → every output is 0 on the next cycle and no write occurs.

Source files
------------

// File: rtl/rom_image_loader_pkg.sv
// Shared definitions for the ROM image loader: FSM states, word geometry
// helpers and the byte order used when packing stream bytes into words.
package rom_image_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } load_state_e;

  typedef enum logic {
    BYTE_ORDER_LE = 1'b0,
    BYTE_ORDER_BE = 1'b1
  } byte_order_e;

  // Any block that re-packs or checksums an image must agree with this order.
  localparam byte_order_e BYTE_ORDER = BYTE_ORDER_LE;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

  function automatic int unsigned byte_idx_width(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/rom_image_loader_byte_packer.sv
// Collects stream bytes into one dw-bit word; upper bytes of a word cut short
// stay zero because the assembly register is cleared between words.
module rom_image_loader_byte_packer
  import rom_image_loader_pkg::*;
#(
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [7:0]    push_data,
  output logic [dw-1:0] word,
  output logic          full
);

  localparam int unsigned NB = bytes_per_word(dw);
  localparam int unsigned IW = byte_idx_width(NB);

  logic [IW-1:0] idx_r;
  logic [IW-1:0] lane_s;
  logic [dw-1:0] word_r;

  // Map the arrival index to a byte lane of the word.
  always_comb begin
    lane_s = idx_r;
    if (BYTE_ORDER == BYTE_ORDER_BE) begin
      lane_s = IW'(NB - 1) - idx_r;
    end else begin
      lane_s = idx_r;
    end
  end

  // Assembly register and byte index.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_r <= '0;
      idx_r  <= '0;
    end else if (push) begin
      word_r[{lane_s, 3'b000} +: 8] <= push_data;
      idx_r <= full ? '0 : idx_r + 1'b1;
    end
  end

  assign full = (idx_r == IW'(NB - 1));
  assign word = word_r;

endmodule

// File: rtl/rom_image_loader.sv
// Packs a host byte stream into dw-bit words and writes them sequentially
// from address 0 into a single-port memory with a one-cycle write strobe.
module rom_image_loader
  import rom_image_loader_pkg::*;
#(
  parameter int aw = 10,
  parameter int dw = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          wr_en,
  output logic [aw-1:0] wr_addr,
  output logic [dw-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic [aw:0]   words_written
);

  if ((dw % 8) != 0 || dw < 8) begin : g_bad_dw
    $error("rom_image_loader: dw must be a positive multiple of 8");
  end

  localparam logic [aw-1:0] ADDR_MAX = '1;

  load_state_e   state_r, state_next;
  logic          in_ready_r, busy_r, wr_en_r, done_r, overflow_r, last_r;
  logic [aw-1:0] addr_r;
  logic [aw:0]   words_r;
  logic          xfer_s, push_s, word_end_s, clear_s;
  logic [dw-1:0] pk_word_s;
  logic          pk_full_s;

  rom_image_loader_byte_packer #(.dw(dw)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (in_data),
    .word      (pk_word_s),
    .full      (pk_full_s)
  );

  // Handshake decode and next-state logic; start overrides every state.
  always_comb begin
    xfer_s     = in_valid & in_ready_r;
    push_s     = xfer_s & ~start & (state_r == COLLECT);
    word_end_s = push_s & (pk_full_s | in_last);
    clear_s    = start | (state_r == WRITE);
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next = COLLECT;
        else       state_next = IDLE;
      end
      COLLECT: begin
        if (start)           state_next = COLLECT;
        else if (word_end_s) state_next = WRITE;
        else                 state_next = COLLECT;
      end
      WRITE: begin
        if (start)                             state_next = COLLECT;
        else if (last_r || addr_r == ADDR_MAX) state_next = DONE;
        else                                   state_next = COLLECT;
      end
      DONE: begin
        if (start)                   state_next = COLLECT;
        else if (last_r)             state_next = IDLE;
        else if (xfer_s && in_last)  state_next = IDLE;
        else                         state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, registered handshake/status outputs, address and word counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      wr_en_r    <= 1'b0;
      done_r     <= 1'b0;
      overflow_r <= 1'b0;
      last_r     <= 1'b0;
      addr_r     <= '0;
      words_r    <= '0;
    end else begin
      state_r    <= state_next;
      in_ready_r <= (state_next == COLLECT) || (state_next == DONE);
      busy_r     <= (state_next == COLLECT) || (state_next == WRITE);
      wr_en_r    <= (state_next == WRITE);
      if (start) begin
        addr_r     <= '0;
        words_r    <= '0;
        done_r     <= 1'b0;
        overflow_r <= 1'b0;
        last_r     <= 1'b0;
      end else begin
        if (state_r == WRITE) begin
          addr_r  <= addr_r + 1'b1;
          words_r <= words_r + 1'b1;
        end
        if (word_end_s) last_r <= in_last;
        if (state_next == DONE) done_r <= 1'b1;
        if (state_r == DONE && xfer_s && !in_last) overflow_r <= 1'b1;
      end
    end
  end

  assign in_ready      = in_ready_r;
  assign wr_en         = wr_en_r;
  assign wr_addr       = addr_r;
  assign wr_data       = pk_word_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign overflow      = overflow_r;
  assign words_written = words_r;

endmodule

// File: tb/tb_rom_image_loader.sv
// Directed bench for rom_image_loader (aw=2, dw=32) with a write scoreboard.
module tb_rom_image_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready, wr_en, busy, done, overflow;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  words_written;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [33:0] exp_q[$];
  logic [33:0] e;
  logic        wr_en_prev = 1'b0;

  rom_image_loader #(.aw(2), .dw(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'(n), 64'(0));
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_overflow"}, 64'(overflow), 64'(0));
    chk({tag, "_words"}, 64'(words_written), 64'(0));
  endtask

  // Scoreboard: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'(1));
      chk("wr_en_gap", 64'(wr_en_prev), 64'(0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e[33:32]));
        chk("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
    end
    wr_en_prev = wr_en;
  end

  initial begin
    logic [7:0] b;
    logic       acc, wend;
    int         nacc;

    // Reset
    wait_cycles(2);
    rst = 1'b0;
    check_all_zero("reset");

    // Two full words, in_last on the 8th byte
    start_pulse();
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_ready", 64'(in_ready), 64'(1));
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) exp_q.push_back({2'd0, 32'h04030201});
      if (i == 8) exp_q.push_back({2'd1, 32'h08070605});
      send_byte(8'(i), i == 8);
    end
    wait_cycles(3);
    chk("dflt_done", 64'(done), 64'(1));
    chk("dflt_words", 64'(words_written), 64'(2));
    chk("dflt_busy", 64'(busy), 64'(0));
    chk("dflt_idle_ready", 64'(in_ready), 64'(0));
    chk("dflt_sb_empty", 64'(exp_q.size()), 64'(0));

    // Partial word is zero padded
    start_pulse();
    chk("restart_done_clr", 64'(done), 64'(0));
    exp_q.push_back({2'd0, 32'h00CCBBAA});
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    wait_cycles(3);
    chk("part_done", 64'(done), 64'(1));
    chk("part_words", 64'(words_written), 64'(1));
    chk("part_sb_empty", 64'(exp_q.size()), 64'(0));

    // Fill the 4-word memory, then 4 excess bytes drain as overflow
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      b = 8'(i + 1);
      if (i < 16 && (i % 4) == 3)
        exp_q.push_back({2'(i / 4), b, b - 8'd1, b - 8'd2, b - 8'd3});
      if (i == 16) chk("full_ovf_before", 64'(overflow), 64'(0));
      send_byte(b, 1'b0);
    end
    wait_cycles(2);
    chk("full_done", 64'(done), 64'(1));
    chk("full_words", 64'(words_written), 64'(4));
    chk("full_overflow", 64'(overflow), 64'(1));
    chk("full_busy", 64'(busy), 64'(0));
    chk("full_drain_ready", 64'(in_ready), 64'(1));
    chk("full_sb_empty", 64'(exp_q.size()), 64'(0));

    // Abort mid-word and restart at address 0
    start_pulse();
    chk("abort_ovf_clr", 64'(overflow), 64'(0));
    chk("abort_done_clr", 64'(done), 64'(0));
    chk("abort_words_clr", 64'(words_written), 64'(0));
    exp_q.push_back({2'd0, 32'h44332211});
    for (int i = 1; i <= 6; i++) send_byte(8'(8'h11 * i), 1'b0);
    start_pulse();
    exp_q.push_back({2'd0, 32'hA4A3A2A1});
    for (int i = 1; i <= 4; i++) send_byte(8'hA0 + 8'(i), i == 4);
    wait_cycles(3);
    chk("abort_words", 64'(words_written), 64'(1));
    chk("abort_done", 64'(done), 64'(1));
    chk("abort_sb_empty", 64'(exp_q.size()), 64'(0));

    // Continuous valid: one-cycle bubble after every 4th byte
    start_pulse();
    nacc = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && nacc < 12; c++) begin
      b = 8'h30 + 8'(nacc);
      in_data = b;
      in_last = (nacc == 11);
      acc  = in_ready;
      wend = acc && ((nacc % 4) == 3);
      if (wend) exp_q.push_back({2'(nacc / 4), b, b - 8'd1, b - 8'd2, b - 8'd3});
      tick();
      chk("bp_wr_en", 64'(wr_en), 64'(wend));
      chk("bp_in_ready", 64'(in_ready), 64'(!wend));
      if (acc) nacc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_bytes", 64'(nacc), 64'(12));
    wait_cycles(3);
    chk("bp_words", 64'(words_written), 64'(3));
    chk("bp_sb_empty", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a word
    start_pulse();
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    wait_cycles(6);
    chk("midrst_sb_empty", 64'(exp_q.size()), 64'(0));
    chk("midrst_idle", 64'(busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
